// File: rtl/ctrl_pipe.sv
// ctrl_pipe: E/M/W control-bit pipeline registers for the 5-stage MIPS datapath.
// Define CTRL_LOAD_USE_EN to enable the internal load-use interlock (stall_req).
module ctrl_pipe #(
   parameter int ALUC_W = 8,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_d,
   input  logic              memtoreg_d,
   input  logic              memwrite_d,
   input  logic              alusrc_d,
   input  logic              regdst_d,
   input  logic              regwrite_d,
   input  logic              write_al_d,
   input  logic [ALUC_W-1:0] alucontrol_d,
   input  logic [REG_W-1:0]  rs_d,
   input  logic [REG_W-1:0]  rt_d,
   input  logic [REG_W-1:0]  rd_d,
   input  logic              stall_e,
   input  logic              stall_m,
   input  logic              flush_e,
   output logic              alusrc_e,
   output logic              regdst_e,
   output logic              memtoreg_e,
   output logic              regwrite_e,
   output logic [ALUC_W-1:0] alucontrol_e,
   output logic [REG_W-1:0]  writereg_e,
   output logic              memwrite_m,
   output logic              memtoreg_m,
   output logic              regwrite_m,
   output logic [REG_W-1:0]  writereg_m,
   output logic              memtoreg_w,
   output logic              regwrite_w,
   output logic [REG_W-1:0]  writereg_w,
   output logic              valid_e,
   output logic              valid_m,
   output logic              valid_w,
   output logic              stall_req
);

`ifdef CTRL_LOAD_USE_EN
   localparam logic LOAD_USE_EN = 1'b1;
`else
   localparam logic LOAD_USE_EN = 1'b0;
`endif

   localparam logic [REG_W-1:0] LINK_REG = REG_W'(31);

   typedef struct packed {
      logic              valid;
      logic              memtoreg;
      logic              memwrite;
      logic              alusrc;
      logic              regdst;
      logic              regwrite;
      logic              write_al;
      logic [ALUC_W-1:0] alucontrol;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  rd;
   } e_stage_t;

   typedef struct packed {
      logic              valid;
      logic              memtoreg;
      logic              memwrite;
      logic              regwrite;
      logic [REG_W-1:0]  writereg;
   } m_stage_t;

   typedef struct packed {
      logic              valid;
      logic              memtoreg;
      logic              regwrite;
      logic [REG_W-1:0]  writereg;
   } w_stage_t;

   e_stage_t e_reg, e_next, d_stage;
   m_stage_t m_reg, m_next, e_to_m;
   w_stage_t w_reg, w_next, m_to_w;

   logic load_use_hit;
   logic flush_int;

   // A D slot without a real instruction enters E as an all-zero bubble.
   always_comb begin
      d_stage = '0;
      if (valid_d) begin
         d_stage.valid      = 1'b1;
         d_stage.memtoreg   = memtoreg_d;
         d_stage.memwrite   = memwrite_d;
         d_stage.alusrc     = alusrc_d;
         d_stage.regdst     = regdst_d;
         d_stage.regwrite   = regwrite_d;
         d_stage.write_al   = write_al_d;
         d_stage.alucontrol = alucontrol_d;
         d_stage.rt         = rt_d;
         d_stage.rd         = rd_d;
      end
   end

   assign writereg_e = e_reg.write_al ? LINK_REG :
                       (e_reg.regdst ? e_reg.rd : e_reg.rt);

   always_comb begin
      e_to_m          = '0;
      e_to_m.valid    = e_reg.valid;
      e_to_m.memtoreg = e_reg.memtoreg;
      e_to_m.memwrite = e_reg.memwrite;
      e_to_m.regwrite = e_reg.regwrite;
      e_to_m.writereg = writereg_e;
   end

   always_comb begin
      m_to_w          = '0;
      m_to_w.valid    = m_reg.valid;
      m_to_w.memtoreg = m_reg.memtoreg;
      m_to_w.regwrite = m_reg.regwrite;
      m_to_w.writereg = m_reg.writereg;
   end

   // Load in E whose destination is read by the instruction sitting in D.
   assign load_use_hit = e_reg.valid & e_reg.memtoreg & (writereg_e != '0) &
                         ((writereg_e == rs_d) | (writereg_e == rt_d));
   assign stall_req    = LOAD_USE_EN & load_use_hit;
   assign flush_int    = flush_e | stall_req;

   // stall_m freezes E and M outright, so it must win over any flush of E.
   always_comb begin
      e_next = e_reg;
      m_next = m_reg;
      w_next = m_to_w;
      if (stall_m) begin
         w_next = '0;
      end else if (flush_int) begin
         e_next = '0;
         m_next = e_to_m;
      end else if (stall_e) begin
         m_next = '0;
      end else begin
         e_next = d_stage;
         m_next = e_to_m;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         e_reg <= '0;
         m_reg <= '0;
         w_reg <= '0;
      end else begin
         e_reg <= e_next;
         m_reg <= m_next;
         w_reg <= w_next;
      end
   end

   assign valid_e      = e_reg.valid;
   assign alusrc_e     = e_reg.alusrc;
   assign regdst_e     = e_reg.regdst;
   assign memtoreg_e   = e_reg.memtoreg;
   assign regwrite_e   = e_reg.regwrite;
   assign alucontrol_e = e_reg.alucontrol;

   assign valid_m      = m_reg.valid;
   assign memwrite_m   = m_reg.memwrite;
   assign memtoreg_m   = m_reg.memtoreg;
   assign regwrite_m   = m_reg.regwrite;
   assign writereg_m   = m_reg.writereg;

   assign valid_w      = w_reg.valid;
   assign memtoreg_w   = w_reg.memtoreg;
   assign regwrite_w   = w_reg.regwrite;
   assign writereg_w   = w_reg.writereg;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: table vectors, load-use sequences and random stimulus for ctrl_pipe,
// checked against an instruction-level model of the E/M/W pipeline.
module tb_ctrl_pipe;
   localparam int ALUC_W = 8;
   localparam int REG_W  = 5;
`ifdef CTRL_LOAD_USE_EN
   localparam bit LU_EN = 1'b1;
`else
   localparam bit LU_EN = 1'b0;
`endif

   localparam int K_NOP  = 0;
   localparam int K_ADD  = 1;
   localparam int K_LW   = 2;
   localparam int K_JAL  = 3;
   localparam int K_ADDI = 4;

   typedef struct packed {
      logic       rst;
      logic       valid;
      logic       memtoreg;
      logic       memwrite;
      logic       alusrc;
      logic       regdst;
      logic       regwrite;
      logic       write_al;
      logic [7:0] aluc;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic       stall_e;
      logic       stall_m;
      logic       flush_e;
   } in_t;

   typedef struct packed {
      logic       valid;
      logic       memtoreg;
      logic       memwrite;
      logic       alusrc;
      logic       regdst;
      logic       regwrite;
      logic       write_al;
      logic [7:0] aluc;
      logic [4:0] rt;
      logic [4:0] rd;
   } ins_t;

   typedef struct {
      in_t in;
      int  ve, we, vm, wm, vw, ww, rw;
   } vec_t;

   logic              clk;
   logic              rst;
   logic              valid_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d, regwrite_d, write_al_d;
   logic [ALUC_W-1:0] alucontrol_d;
   logic [REG_W-1:0]  rs_d, rt_d, rd_d;
   logic              stall_e, stall_m, flush_e;
   logic              alusrc_e, regdst_e, memtoreg_e, regwrite_e;
   logic [ALUC_W-1:0] alucontrol_e;
   logic [REG_W-1:0]  writereg_e, writereg_m, writereg_w;
   logic              memwrite_m, memtoreg_m, regwrite_m;
   logic              memtoreg_w, regwrite_w;
   logic              valid_e, valid_m, valid_w;
   logic              stall_req;

   int n_pass  = 0;
   int n_total = 0;

   ins_t st_e = '0;
   ins_t st_m = '0;
   ins_t st_w = '0;
   bit   model_known = 1'b0;

   vec_t vecs[25];

   ctrl_pipe #(.ALUC_W(ALUC_W), .REG_W(REG_W)) dut (
      .clk(clk), .rst(rst),
      .valid_d(valid_d), .memtoreg_d(memtoreg_d), .memwrite_d(memwrite_d),
      .alusrc_d(alusrc_d), .regdst_d(regdst_d), .regwrite_d(regwrite_d),
      .write_al_d(write_al_d), .alucontrol_d(alucontrol_d),
      .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
      .stall_e(stall_e), .stall_m(stall_m), .flush_e(flush_e),
      .alusrc_e(alusrc_e), .regdst_e(regdst_e), .memtoreg_e(memtoreg_e),
      .regwrite_e(regwrite_e), .alucontrol_e(alucontrol_e), .writereg_e(writereg_e),
      .memwrite_m(memwrite_m), .memtoreg_m(memtoreg_m), .regwrite_m(regwrite_m),
      .writereg_m(writereg_m),
      .memtoreg_w(memtoreg_w), .regwrite_w(regwrite_w), .writereg_w(writereg_w),
      .valid_e(valid_e), .valid_m(valid_m), .valid_w(valid_w),
      .stall_req(stall_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Destination register an instruction writes back, by the ISA rules.
   function automatic logic [4:0] dest(ins_t s);
      if (!s.valid) return 5'd0;
      if (s.write_al) return 5'd31;
      return s.regdst ? s.rd : s.rt;
   endfunction

   function automatic ins_t decode(in_t i);
      ins_t s = '0;
      if (i.valid) begin
         s.valid    = 1'b1;
         s.memtoreg = i.memtoreg;
         s.memwrite = i.memwrite;
         s.alusrc   = i.alusrc;
         s.regdst   = i.regdst;
         s.regwrite = i.regwrite;
         s.write_al = i.write_al;
         s.aluc     = i.aluc;
         s.rt       = i.rt;
         s.rd       = i.rd;
      end
      return s;
   endfunction

   function automatic bit hazard(in_t i);
      logic [4:0] d = dest(st_e);
      return LU_EN && st_e.valid && st_e.memtoreg && (d != 5'd0) && (d == i.rs || d == i.rt);
   endfunction

   // Moves instruction records between stages for one clock edge.
   function automatic void model_step(in_t i);
      bit flush = i.flush_e || hazard(i);
      if (i.rst) begin
         st_e = '0; st_m = '0; st_w = '0;
      end else if (i.stall_m) begin
         st_w = '0;
      end else if (flush) begin
         st_w = st_m; st_m = st_e; st_e = '0;
      end else if (i.stall_e) begin
         st_w = st_m; st_m = '0;
      end else begin
         st_w = st_m; st_m = st_e; st_e = decode(i);
      end
      model_known = 1'b1;
   endfunction

   function automatic in_t op(int kind, int r);
      in_t i = '0;
      case (kind)
         K_ADD:  begin i.valid = 1; i.regdst = 1; i.regwrite = 1; i.aluc = 8'h20; i.rd = 5'(r); i.rt = 5'd3; end
         K_LW:   begin i.valid = 1; i.memtoreg = 1; i.regwrite = 1; i.alusrc = 1; i.aluc = 8'h21; i.rt = 5'(r); i.rd = 5'd4; end
         K_JAL:  begin i.valid = 1; i.write_al = 1; i.regwrite = 1; i.aluc = 8'h22; i.rd = 5'd2; i.rt = 5'd7; end
         K_ADDI: begin i.valid = 1; i.alusrc = 1; i.regwrite = 1; i.aluc = 8'h23; i.rt = 5'(r); end
         default: ;
      endcase
      return i;
   endfunction

   function automatic in_t ctl(in_t i, bit r, bit se, bit sm, bit fl);
      in_t o = i;
      o.rst = r; o.stall_e = se; o.stall_m = sm; o.flush_e = fl;
      return o;
   endfunction

   function automatic vec_t mk(in_t i, int ve, int we, int vm, int wm, int vw, int ww, int rw);
      vec_t v;
      v.in = i; v.ve = ve; v.we = we; v.vm = vm; v.wm = wm; v.vw = vw; v.ww = ww; v.rw = rw;
      return v;
   endfunction

   function automatic logic [4:0] pick_reg();
      case ($urandom_range(0, 3))
         0:       return 5'd0;
         1:       return 5'd9;
         2:       return 5'($urandom_range(1, 3));
         default: return 5'($urandom);
      endcase
   endfunction

   function automatic in_t rand_in();
      in_t i;
      i.rst      = ($urandom_range(0, 49) == 0);
      i.valid    = ($urandom_range(0, 3) != 0);
      i.memtoreg = 1'($urandom_range(0, 1));
      i.memwrite = 1'($urandom_range(0, 1));
      i.alusrc   = 1'($urandom_range(0, 1));
      i.regdst   = 1'($urandom_range(0, 1));
      i.regwrite = 1'($urandom_range(0, 1));
      i.write_al = ($urandom_range(0, 4) == 0);
      i.aluc     = 8'($urandom);
      i.rs       = pick_reg();
      i.rt       = pick_reg();
      i.rd       = pick_reg();
      i.stall_e  = ($urandom_range(0, 5) == 0);
      i.stall_m  = ($urandom_range(0, 7) == 0);
      i.flush_e  = ($urandom_range(0, 7) == 0);
      return i;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic drive(input in_t i);
      rst = i.rst; valid_d = i.valid; memtoreg_d = i.memtoreg; memwrite_d = i.memwrite;
      alusrc_d = i.alusrc; regdst_d = i.regdst; regwrite_d = i.regwrite; write_al_d = i.write_al;
      alucontrol_d = i.aluc; rs_d = i.rs; rt_d = i.rt; rd_d = i.rd;
      stall_e = i.stall_e; stall_m = i.stall_m; flush_e = i.flush_e;
   endtask

   task automatic check_stages();
      check("e_stage",
            32'({valid_e, alusrc_e, regdst_e, memtoreg_e, regwrite_e, alucontrol_e, writereg_e}),
            32'({st_e.valid, st_e.alusrc, st_e.regdst, st_e.memtoreg, st_e.regwrite, st_e.aluc, dest(st_e)}));
      check("m_stage",
            32'({valid_m, memwrite_m, memtoreg_m, regwrite_m, writereg_m}),
            32'({st_m.valid, st_m.memwrite, st_m.memtoreg, st_m.regwrite, dest(st_m)}));
      check("w_stage",
            32'({valid_w, memtoreg_w, regwrite_w, writereg_w}),
            32'({st_w.valid, st_w.memtoreg, st_w.regwrite, dest(st_w)}));
   endtask

   // One transaction: apply D-side inputs, check stall_req, clock, check all stages.
   task automatic tick(input in_t i);
      drive(i);
      #1;
      if (model_known) check("stall_req", 32'(stall_req), 32'(hazard(i)));
      @(posedge clk);
      model_step(i);
      #1;
      check_stages();
      $display("t=%0t rst=%0b vd=%0b se=%0b sm=%0b fl=%0b | E v=%0b wr=%0d | M v=%0b wr=%0d | W v=%0b wr=%0d rw=%0b | sreq=%0b",
               $time, i.rst, i.valid, i.stall_e, i.stall_m, i.flush_e,
               valid_e, writereg_e, valid_m, writereg_m, valid_w, writereg_w, regwrite_w, stall_req);
   endtask

   initial begin
      in_t d;

      vecs[0]  = mk(ctl(op(K_ADDI, 5), 1, 0, 0, 0), 0, 0,  0, 0,  0, 0,  0);
      vecs[1]  = mk(ctl(op(K_ADDI, 5), 1, 0, 0, 0), 0, 0,  0, 0,  0, 0,  0);
      vecs[2]  = mk(ctl(op(K_ADDI, 5), 0, 0, 0, 0), 1, 5,  0, 0,  0, 0,  0);
      vecs[3]  = mk(ctl(op(K_ADDI, 5), 0, 0, 0, 0), 1, 5,  1, 5,  0, 0,  0);
      vecs[4]  = mk(ctl(op(K_ADDI, 5), 0, 0, 0, 0), 1, 5,  1, 5,  1, 5,  1);
      vecs[5]  = mk(ctl(op(K_ADD, 8),  0, 0, 0, 0), 1, 8,  1, 5,  1, 5,  1);
      vecs[6]  = mk(ctl(op(K_LW, 9),   0, 0, 0, 0), 1, 9,  1, 8,  1, 5,  1);
      vecs[7]  = mk(ctl(op(K_JAL, 0),  0, 0, 0, 0), 1, 31, 1, 9,  1, 8,  1);
      vecs[8]  = mk(ctl(op(K_NOP, 0),  0, 0, 0, 0), 0, 0,  1, 31, 1, 9,  1);
      vecs[9]  = mk(ctl(op(K_NOP, 0),  0, 0, 0, 0), 0, 0,  0, 0,  1, 31, 1);
      vecs[10] = mk(ctl(op(K_ADD, 8),  0, 0, 0, 0), 1, 8,  0, 0,  0, 0,  0);
      vecs[11] = mk(ctl(op(K_LW, 9),   0, 0, 0, 0), 1, 9,  1, 8,  0, 0,  0);
      vecs[12] = mk(ctl(op(K_ADD, 10), 0, 1, 0, 0), 1, 9,  0, 0,  1, 8,  1);
      vecs[13] = mk(ctl(op(K_ADD, 10), 0, 1, 0, 0), 1, 9,  0, 0,  0, 0,  0);
      vecs[14] = mk(ctl(op(K_ADD, 10), 0, 0, 0, 0), 1, 10, 1, 9,  0, 0,  0);
      vecs[15] = mk(ctl(op(K_NOP, 0),  0, 0, 0, 0), 0, 0,  1, 10, 1, 9,  1);
      vecs[16] = mk(ctl(op(K_ADD, 8),  0, 0, 0, 0), 1, 8,  0, 0,  1, 10, 1);
      vecs[17] = mk(ctl(op(K_LW, 9),   0, 0, 0, 0), 1, 9,  1, 8,  0, 0,  0);
      vecs[18] = mk(ctl(op(K_ADD, 10), 0, 0, 1, 1), 1, 9,  1, 8,  0, 0,  0);
      vecs[19] = mk(ctl(op(K_NOP, 0),  0, 0, 0, 0), 0, 0,  1, 9,  1, 8,  1);
      vecs[20] = mk(ctl(op(K_ADD, 12), 0, 0, 0, 0), 1, 12, 0, 0,  1, 9,  1);
      vecs[21] = mk(ctl(op(K_ADD, 13), 0, 0, 0, 1), 0, 0,  1, 12, 0, 0,  0);
      vecs[22] = mk(ctl(op(K_ADD, 14), 0, 0, 0, 0), 1, 14, 0, 0,  1, 12, 1);
      vecs[23] = mk(ctl(op(K_ADD, 14), 0, 1, 0, 1), 0, 0,  1, 14, 0, 0,  0);
      vecs[24] = mk(ctl(op(K_NOP, 0),  0, 0, 0, 0), 0, 0,  0, 0,  1, 14, 1);

      for (int k = 0; k < 25; k++) begin
         tick(vecs[k].in);
         check($sformatf("v%0d_valid_e", k),    32'(valid_e),    32'(vecs[k].ve));
         check($sformatf("v%0d_writereg_e", k), 32'(writereg_e), 32'(vecs[k].we));
         check($sformatf("v%0d_valid_m", k),    32'(valid_m),    32'(vecs[k].vm));
         check($sformatf("v%0d_writereg_m", k), 32'(writereg_m), 32'(vecs[k].wm));
         check($sformatf("v%0d_valid_w", k),    32'(valid_w),    32'(vecs[k].vw));
         check($sformatf("v%0d_writereg_w", k), 32'(writereg_w), 32'(vecs[k].ww));
         check($sformatf("v%0d_regwrite_w", k), 32'(regwrite_w), 32'(vecs[k].rw));
      end

      // Load-use: lw $9 in E while D reads $9 through rs.
      tick(op(K_LW, 9));
      d = op(K_ADD, 8);
      d.rs = 5'd9;
      drive(d);
      #1;
      check("lu_stall_req_hit", 32'(stall_req), 32'(LU_EN));
      tick(d);
      check("lu_valid_e_after", 32'(valid_e), LU_EN ? 32'd0 : 32'd1);
      check("lu_writereg_e_after", 32'(writereg_e), LU_EN ? 32'd0 : 32'd8);
      tick(op(K_NOP, 0));

      // A load to $0 never interlocks, even when D reads $0.
      tick(op(K_LW, 0));
      d = op(K_ADD, 8);
      d.rs = 5'd0;
      drive(d);
      #1;
      check("lu_stall_req_r0", 32'(stall_req), 32'd0);
      tick(d);
      check("lu_r0_valid_e", 32'(valid_e), 32'd1);
      check("lu_r0_writereg_e", 32'(writereg_e), 32'd8);

      tick(ctl(op(K_NOP, 0), 1, 0, 0, 0));
      for (int n = 0; n < 400; n++) tick(rand_in());

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
